// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: samples async pwm_in, outputs period/high_time in clk cycles, duty in tenths, a one-cycle valid pulse and a static-input timeout level
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [3:0]       duty,
  output logic             valid,
  output logic             timeout
);
  localparam int REM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic {IDLE, DIV} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] pend_per_q, pend_per_d, pend_hi_q, pend_hi_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [3:0] q_q, q_d, duty_q, duty_d;
  logic armed_q, armed_d, valid_q, valid_d, timeout_q, timeout_d;
  logic rise, at_to, fire, capture, div_go, done;
  assign rise    = s2_q & ~s3_q;
  assign at_to   = per_cnt_q == TO;
  // timeout_q doubles as the once-per-stall guard: only a rise can restart the counter and clear it
  assign fire    = at_to & ~rise & ~timeout_q;
  assign capture = rise & armed_q & (state_q == IDLE);
  assign div_go  = (state_q == DIV) && (rem_q >= {4'b0, pend_per_q});
  assign done    = (state_q == DIV) && !div_go && !fire;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = fire ? IDLE : capture ? DIV : done ? IDLE : state_q;
  always_comb begin
    s1_d        = pwm_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    per_cnt_d   = rise ? CNT_W'(1) : at_to ? per_cnt_q : per_cnt_q + CNT_W'(1);
    hi_cnt_d    = rise ? CNT_W'(1) : (s2_q && hi_cnt_q != MAX) ? hi_cnt_q + CNT_W'(1) : hi_cnt_q;
    armed_d     = fire ? 1'b0 : rise ? 1'b1 : armed_q;
    pend_per_d  = capture ? per_cnt_q : pend_per_q;
    pend_hi_d   = capture ? hi_cnt_q : pend_hi_q;
    rem_d       = capture ? REM_W'(hi_cnt_q) * REM_W'(10) : div_go ? rem_q - {4'b0, pend_per_q} : rem_q;
    q_d         = capture ? 4'd0 : div_go ? q_q + 4'd1 : q_q;
    period_d    = fire ? '0 : done ? pend_per_q : period_q;
    high_time_d = fire ? '0 : done ? pend_hi_q : high_time_q;
    duty_d      = fire ? (s2_q ? 4'd10 : 4'd0) : done ? q_q : duty_q;
    valid_d     = fire | done;
    timeout_d   = fire ? 1'b1 : rise ? 1'b0 : timeout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      armed_q     <= 1'b0;
      pend_per_q  <= '0;
      pend_hi_q   <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      armed_q     <= armed_d;
      pend_per_q  <= pend_per_d;
      pend_hi_q   <= pend_hi_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end
  assign period    = period_q;
  assign high_time = high_time_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
endmodule
